// File: rtl/pc_fetch_unit.sv
// Registered next-PC unit: owns the PC, issues fetch requests with valid/ready,
// and parks redirects that arrive while a request is being back-pressured.
module pc_fetch_unit #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               BOOT_DELAY   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCImm,
  input  logic [XLEN-1:0] ALUres,
  input  logic [XLEN-1:0] TrapVec,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCplus4,
  output logic            misalign,
  output logic [XLEN-1:0] fetch_count
);

  localparam int CW = $clog2(BOOT_DELAY) + 1;

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state_reg;
  logic [CW-1:0]   boot_cnt_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pending_reg;
  logic [XLEN-1:0] count_reg;
  logic            valid_reg;
  logic            misalign_reg;

  logic            redirect;
  logic            target_bad;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic            unused_alu_bit;

  assign unused_alu_bit = ALUres[0];

  // Only branch/JAL and JALR targets are alignment-checked; a bad one is
  // replaced by the trap vector so the core fetches the handler instead.
  always_comb begin
    target_raw = PCImm;
    case (PCSrc)
      2'b01:   target_raw = PCImm;
      2'b10:   target_raw = {ALUres[XLEN-1:1], 1'b0};
      2'b11:   target_raw = TrapVec;
      default: target_raw = PCImm;
    endcase
    redirect   = (PCSrc != 2'b00);
    target_bad = ((PCSrc == 2'b01) || (PCSrc == 2'b10)) && target_raw[1];
    target     = target_bad ? TrapVec : target_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= BOOT;
      boot_cnt_reg <= CW'(BOOT_DELAY - 1);
      pc_reg       <= RESET_VECTOR;
      pending_reg  <= '0;
      count_reg    <= '0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= 1'b0;
      if (valid_reg && fetch_ready) begin
        count_reg <= count_reg + XLEN'(1);
      end
      case (state_reg)
        BOOT: begin
          if (boot_cnt_reg == '0) begin
            state_reg <= RUN;
            valid_reg <= 1'b1;
          end else begin
            boot_cnt_reg <= boot_cnt_reg - CW'(1);
          end
        end
        RUN: begin
          if (redirect) begin
            misalign_reg <= target_bad;
            if (fetch_ready || !valid_reg) begin
              pc_reg <= target;
            end else begin
              // Request is being held by imem: park the target, keep PC stable.
              pending_reg <= target;
              state_reg   <= HOLD;
            end
          end else if (fetch_ready && !stall) begin
            pc_reg <= pc_reg + XLEN'(4);
          end
        end
        HOLD: begin
          if (redirect) begin
            misalign_reg <= target_bad;
          end
          if (fetch_ready) begin
            pc_reg    <= redirect ? target : pending_reg;
            state_reg <= RUN;
          end else if (redirect) begin
            pending_reg <= target;
          end
        end
        default: begin
          state_reg <= BOOT;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid = valid_reg;
  assign PC          = pc_reg;
  assign PCplus4     = pc_reg + XLEN'(4);
  assign misalign    = misalign_reg;
  assign fetch_count = count_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus random traffic
// against a cycle-level reference model, and a narrow instance for wrap checks.
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h100;
  localparam int          BD = 4;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_ready;
  logic [1:0]  PCSrc;
  logic [31:0] PCImm, ALUres, TrapVec;
  logic        fetch_valid, misalign;
  logic [31:0] PC, PCplus4, fetch_count;

  logic        b_rst, b_ready, b_valid, b_mis;
  logic [7:0]  b_pc, b_pc4, b_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc, m_pend, m_cnt;
  logic        m_valid, m_mis, m_hold;
  int          m_boot;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(RV), .BOOT_DELAY(BD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .PCImm(PCImm),
    .ALUres(ALUres), .TrapVec(TrapVec), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .PC(PC), .PCplus4(PCplus4),
    .misalign(misalign), .fetch_count(fetch_count)
  );

  pc_fetch_unit #(.XLEN(8), .RESET_VECTOR(8'hF0), .BOOT_DELAY(1)) dut_b (
    .clk(clk), .rst(b_rst), .stall(1'b0), .PCSrc(2'b00), .PCImm(8'h00),
    .ALUres(8'h00), .TrapVec(8'h40), .fetch_ready(b_ready),
    .fetch_valid(b_valid), .PC(b_pc), .PCplus4(b_pc4),
    .misalign(b_mis), .fetch_count(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
  endtask

  // One rising edge of the intended behaviour, using the inputs now applied.
  task automatic model_step();
    logic [31:0] t;
    logic        bad, redir;
    if (rst) begin
      m_pc = RV; m_valid = 0; m_mis = 0; m_cnt = 0;
      m_boot = BD; m_hold = 0; m_pend = 0;
    end else if (!m_valid) begin
      m_mis  = 0;
      m_boot = m_boot - 1;
      if (m_boot == 0) m_valid = 1;
    end else begin
      redir = (PCSrc != 0);
      t = (PCSrc == 1) ? PCImm : (PCSrc == 2) ? (ALUres & ~32'd1) : TrapVec;
      bad = (PCSrc == 1 || PCSrc == 2) && t[1];
      if (bad) t = TrapVec;
      m_mis = redir && bad;
      if (fetch_ready) begin
        m_cnt = m_cnt + 1;
        if (redir)       m_pc = t;
        else if (m_hold) m_pc = m_pend;
        else if (!stall) m_pc = m_pc + 4;
        m_hold = 0;
      end else if (redir) begin
        m_pend = t;
        m_hold = 1;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic st, input logic [1:0] src,
                     input logic [31:0] imm, input logic [31:0] alu, input logic rdy);
    rst = r; stall = st; PCSrc = src; PCImm = imm; ALUres = alu; fetch_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    $display("cyc rst=%0b stall=%0b src=%0d rdy=%0b -> PC=0x%08h valid=%0b mis=%0b cnt=%0d",
             r, st, src, rdy, PC, fetch_valid, misalign, fetch_count);
    check("pc", PC, m_pc);
    check("pcplus4", PCplus4, m_pc + 32'd4);
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
    check("misalign", {31'd0, misalign}, {31'd0, m_mis});
    check("fetch_count", fetch_count, m_cnt);
  endtask

  initial begin
    int n;
    bit seen;
    TrapVec = 32'h80;
    b_rst = 1'b1; b_ready = 1'b0;
    rst = 1'b1; stall = 1'b0; PCSrc = 2'b00; PCImm = '0; ALUres = '0; fetch_ready = 1'b0;

    // Reset and boot, then streaming fetches
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    repeat (7) cyc(0, 0, 0, 0, 0, 1);
    // Stall with ready still high
    cyc(0, 0, 1, 32'h200, 0, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Redirect under backpressure, last pending target wins
    cyc(0, 0, 1, 32'h300, 0, 1);
    cyc(0, 0, 1, 32'h400, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h500, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // Redirect coinciding with the ready cycle of HOLD
    cyc(0, 0, 1, 32'h600, 0, 0);
    cyc(0, 1, 1, 32'h700, 0, 1);
    // JALR: misaligned then aligned after bit-0 clear
    cyc(0, 0, 2, 0, 32'h0803, 1);
    cyc(0, 0, 2, 0, 32'h0805, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Misaligned target latched in HOLD
    cyc(0, 0, 1, 32'h0A02, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // Address wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    // Reset in the middle of HOLD
    cyc(0, 0, 1, 32'h400, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 32'h900, 0, 0);
    repeat (7) cyc(0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] imm, alu;
      imm = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
      alu = $urandom;
      if ($urandom_range(0, 15) == 0) TrapVec = $urandom & 32'hFFFF_FFFC;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
          (($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0),
          imm, alu, ($urandom_range(0, 2) != 0));
    end

    // Narrow instance: PC and fetch_count both wrap modulo 2^8
    @(negedge clk);
    b_rst = 1'b1; b_ready = 1'b1;
    repeat (2) @(negedge clk);
    b_rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b_valid) begin seen = 1; break; end
    end
    check("b_boot_timeout", {31'd0, seen}, 32'd1);
    if (seen) begin
      n = 0;
      repeat (300) begin
        check("b_pc", {24'd0, b_pc}, {24'd0, 8'(32'hF0 + 4 * n)});
        check("b_fetch_count", {24'd0, b_cnt}, {24'd0, 8'(n)});
        @(negedge clk);
        n++;
      end
      $display("narrow instance: %0d accepted fetches, PC=0x%02h cnt=%0d", n, b_pc, b_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
